disp_share_arb: RTL



---
 rtl/disp_pkg.sv | 27 ++
 rtl/rr_pick.sv | 33 +++
 rtl/disp_share_arb.sv | 128 ++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared types and elaboration helpers for the display-sharing arbiter.
package disp_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned DIGITS   = 4;
  localparam int unsigned VALUE_W  = NIBBLE_W * DIGITS;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StOpen = 2'd2
  } state_e;

  function automatic int unsigned hold_cycles(input int unsigned freq_hz, input int unsigned ms);
    return freq_hz / 1000 * ms;
  endfunction

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin requester selection: first eligible req after 'last', skipping excluded ones.
module rr_pick
  import disp_pkg::*;
#(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  input  logic [NREQ-1:0]  excl,
  output logic [NREQ-1:0]  pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             valid
);

  int unsigned k;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    valid    = 1'b0;
    k        = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      k = (32'(last) + i) % NREQ;
      if (!valid && req[k] && !excl[k]) begin
        pick[k]  = 1'b1;
        pick_idx = IDX_W'(k);
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_share_arb.sv
// Shares one 4-digit 7-segment display among NREQ requesters, round-robin with minimum hold.
module disp_share_arb
  import disp_pkg::*;
#(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned CLK_FREQ_HZ = 12000000,
  parameter int unsigned HOLD_MS     = 1000,
  parameter logic [15:0] IDLE_VALUE  = 16'h0000,
  parameter logic [3:0]  IDLE_DP     = 4'b0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [VALUE_W*NREQ-1:0]   data_in,
  input  logic [DIGITS*NREQ-1:0]    dp_in,
  output logic [NREQ-1:0]           gnt,
  output logic [NIBBLE_W-1:0]       hex0,
  output logic [NIBBLE_W-1:0]       hex1,
  output logic [NIBBLE_W-1:0]       hex2,
  output logic [NIBBLE_W-1:0]       hex3,
  output logic [DIGITS-1:0]         dp_out,
  output logic                      busy
);

  localparam int unsigned HOLD_CYCLES = hold_cycles(CLK_FREQ_HZ, HOLD_MS);
  localparam int unsigned CNT_W       = clog2(HOLD_CYCLES + 1);
  localparam int unsigned IDX_W       = (NREQ > 1) ? clog2(NREQ) : 1;

  state_e             state_q;
  logic [NREQ-1:0]    gnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   last_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [VALUE_W-1:0] value_q;
  logic [DIGITS-1:0]  dp_q;
  logic               busy_q;

  logic [NREQ-1:0]    pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               holder_req;
  logic               do_grant;
  logic               do_release;

  // Excluding the holder lets OPEN look for a challenger; in IDLE gnt_q is zero.
  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req      (req),
    .last     (last_q),
    .excl     (gnt_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .valid    (pick_valid)
  );

  assign holder_req = |(req & gnt_q);

  always_comb begin
    do_grant   = 1'b0;
    do_release = 1'b0;
    unique case (state_q)
      StIdle: do_grant = pick_valid;
      StHold: begin
        if (!holder_req) begin
          do_grant   = pick_valid;
          do_release = !pick_valid;
        end
      end
      StOpen: begin
        if (!holder_req) begin
          do_grant   = pick_valid;
          do_release = !pick_valid;
        end else begin
          do_grant = pick_valid;
        end
      end
      default: do_release = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= IDX_W'(NREQ - 1);
      cnt_q   <= '0;
      value_q <= IDLE_VALUE;
      dp_q    <= IDLE_DP;
      busy_q  <= 1'b0;
    end else if (do_grant) begin
      state_q <= StHold;
      gnt_q   <= pick;
      idx_q   <= pick_idx;
      last_q  <= pick_idx;
      cnt_q   <= CNT_W'(HOLD_CYCLES - 1);
      value_q <= data_in[VALUE_W*pick_idx +: VALUE_W];
      dp_q    <= dp_in[DIGITS*pick_idx +: DIGITS];
      busy_q  <= 1'b1;
    end else if (do_release) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      cnt_q   <= '0;
      value_q <= IDLE_VALUE;
      dp_q    <= IDLE_DP;
      busy_q  <= 1'b0;
    end else if (state_q != StIdle) begin
      // Holder keeps the display; follow its live data.
      value_q <= data_in[VALUE_W*idx_q +: VALUE_W];
      dp_q    <= dp_in[DIGITS*idx_q +: DIGITS];
      if (state_q == StHold) begin
        if (cnt_q == '0) state_q <= StOpen;
        else cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign gnt    = gnt_q;
  assign hex0   = value_q[3:0];
  assign hex1   = value_q[7:4];
  assign hex2   = value_q[11:8];
  assign hex3   = value_q[15:12];
  assign dp_out = dp_q;
  assign busy   = busy_q;

endmodule
